axi_master_arbiter: RTL and testbench
=====================================

Name: axi_master_arbiter

Overview:
Arbitrates one AXI4 slave port (CLINT / memory bridge) between two masters: M0 = instruction fetch (read-only) and M1 = load/store unit (read and write). Exactly one transaction is in flight at a time, and the whole transaction (address, all data beats, response) is granted to one master. Round-robin arbitration between M0 and M1; within M1, write wins over read. Sits between IFU/LSU and the slave-side interconnect.

Parameters:
AW, 32, address width
DW, 64, data width
IDW, 4, ID width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
m0_ar{valid,id,addr,len,size,burst}  in  1/IDW/AW/8/3/2  M0 read address channel
m0_arready  out  1  M0 read address accept
m0_r{valid,id,resp,data,last}  out  1/IDW/2/DW/1  M0 read data channel
m0_rready  in  1  M0 read data accept
m1_ar{valid,id,addr,len,size,burst}  in  1/IDW/AW/8/3/2  M1 read address channel
m1_arready  out  1  M1 read address accept
m1_r{valid,id,resp,data,last}  out  1/IDW/2/DW/1  M1 read data channel
m1_rready  in  1  M1 read data accept
m1_aw{valid,id,addr,len,size,burst}  in  1/IDW/AW/8/3/2  M1 write address channel
m1_awready  out  1  M1 write address accept
m1_w{valid,data,strb,last}  in  1/DW/DW/8/1  M1 write data channel
m1_wready  out  1  M1 write data accept
m1_b{valid,id,resp}  out  1/IDW/2  M1 write response channel
m1_bready  in  1  M1 write response accept
s_ar*, s_aw*, s_w*, s_rready, s_bready  out  (as above)  slave-side requests
s_arready, s_awready, s_wready, s_r*, s_bvalid/bid/bresp  in  (as above)  slave-side responses

Behaviour:
- Registered state: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP. Registered owner (0/1) and last_grant (0/1).
- Reset (rst=0, async): state=IDLE, owner=0, last_grant=1. All valid and ready outputs are 0; data, id and resp outputs are 0.
- IDLE:
  - No outputs asserted.
  - Requests: req0 = m0_arvalid; req1 = m1_arvalid | m1_awvalid.
  - Exactly one request: grant it.
  - Both: grant !last_grant.
  - On granting M1: m1_awvalid → WADDR, else → RADDR. On granting M0 → RADDR.
  - On a grant, owner and last_grant both take the granted index. No request: stay in IDLE.
  - The grant takes effect next cycle, so the minimum latency from arvalid to s_arvalid is 1 cycle.
- RADDR:
  - The owner's ar* is forwarded combinationally to s_ar*.
  - s_arready is returned to the owner's arready only.
  - On s_arvalid & s_arready → RDATA.
  - If the owner drops arvalid, wait indefinitely; no timeout.
- RDATA:
  - s_r* is forwarded to the owner's r*; the owner's rready is forwarded to s_rready.
  - On s_rvalid & s_rready & s_rlast → IDLE. Multi-beat bursts pass through unchanged.
- WADDR: m1_aw* ↔ s_aw*. On handshake → WDATA.
- WDATA: m1_w* ↔ s_w*. On handshake with wlast=1 → WRESP.
- WRESP: s_b* → m1_b*, m1_bready → s_bready. On handshake → IDLE.
- Isolation:
  - The non-owner master sees all its ready/valid outputs at 0 in every state.
  - Slave-side channels not used by the current state drive valid/ready = 0 and payload = 0.
- Responses are passed unmodified: rid, bid, rresp and bresp are not remapped.
- A pending non-granted request is held off. Its valid stays high with ready=0, so it waits at most one foreign transaction (round-robin fairness).
- Simultaneous m1_awvalid and m1_arvalid on an M1 grant: write first. The read is served at the next M1 grant.
- Reset asserted mid-transaction: immediate return to IDLE with all valids dropped. The slave is reset by the same rst.
- Back-to-back: IDLE is always visited for one cycle between transactions (1 bubble).

Test Plan:
- Reset behaviour: hold rst=0, then release → all outputs 0; M0 wins the first tie (last_grant=1).
- Single M0 read, addr=0x0200_bff8, len=0, slave returns rdata=0x1234 → s_arvalid 1 cycle after m0_arvalid; m0_rdata=0x1234 with rlast=1; m1 outputs all 0 throughout.
- M0 read and M1 read raised in the same cycle, repeated 4 times → grants alternate M0, M1, M0, M1; each waiting master sees arready=0 until granted.
- M1 write, addr=0x0200_4000, wdata=0x10, wstrb=0xFF → s_aw handshake, then s_w with wlast, then m1_bvalid with bresp=OKAY; then IDLE.
- M1 aw and ar both valid, M0 idle → write completes fully before s_arvalid is asserted for the M1 read.
- Read burst len=3 with the slave stalling rvalid randomly → 4 beats delivered in order, return to IDLE only after rlast. Then assert rst=0 mid-burst → all valids 0 immediately, state IDLE.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// Two-master AXI4 arbiter: one whole transaction in flight, round-robin M0/M1, M1 write before M1 read.
// Grant takes one cycle from IDLE; channels are combinational pass-through, so backpressure flows owner<->slave.
module axi_master_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
) (
  input  logic              clk,
  input  logic              rst,
  // M0: instruction fetch, read-only
  input  logic              m0_arvalid,
  input  logic [IDW-1:0]    m0_arid,
  input  logic [AW-1:0]     m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [IDW-1:0]    m0_rid,
  output logic [1:0]        m0_rresp,
  output logic [DW-1:0]     m0_rdata,
  output logic              m0_rlast,
  input  logic              m0_rready,
  // M1: load/store unit
  input  logic              m1_arvalid,
  input  logic [IDW-1:0]    m1_arid,
  input  logic [AW-1:0]     m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [IDW-1:0]    m1_rid,
  output logic [1:0]        m1_rresp,
  output logic [DW-1:0]     m1_rdata,
  output logic              m1_rlast,
  input  logic              m1_rready,
  input  logic              m1_awvalid,
  input  logic [IDW-1:0]    m1_awid,
  input  logic [AW-1:0]     m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [IDW-1:0]    m1_bid,
  output logic [1:0]        m1_bresp,
  input  logic              m1_bready,
  // slave side
  output logic              s_arvalid,
  output logic [IDW-1:0]    s_arid,
  output logic [AW-1:0]     s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [IDW-1:0]    s_rid,
  input  logic [1:0]        s_rresp,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic              s_awvalid,
  output logic [IDW-1:0]    s_awid,
  output logic [AW-1:0]     s_awaddr,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wstrb,
  output logic              s_wlast,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [IDW-1:0]    s_bid,
  input  logic [1:0]        s_bresp,
  output logic              s_bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last_grant, last_grant_nxt;
  logic   req1;
  logic   ar_vld_sel;
  logic   r_rdy_sel;

  assign req1 = m1_arvalid | m1_awvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    ar_vld_sel     = owner ? m1_arvalid : m0_arvalid;
    r_rdy_sel      = owner ? m1_rready  : m0_rready;

    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rid     = '0;
    m0_rresp   = '0;
    m0_rdata   = '0;
    m0_rlast   = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rid     = '0;
    m1_rresp   = '0;
    m1_rdata   = '0;
    m1_rlast   = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bid     = '0;
    m1_bresp   = '0;
    s_arvalid  = 1'b0;
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awid     = '0;
    s_awaddr   = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;

    case (state)
      IDLE: begin
        // On a tie M0 wins only if M1 had the previous grant.
        if (m0_arvalid && (!req1 || last_grant)) begin
          owner_nxt      = 1'b0;
          last_grant_nxt = 1'b0;
          state_nxt      = RADDR;
        end else if (req1) begin
          owner_nxt      = 1'b1;
          last_grant_nxt = 1'b1;
          state_nxt      = m1_awvalid ? WADDR : RADDR;
        end
      end

      RADDR: begin
        if (owner) begin
          s_arvalid  = m1_arvalid;
          s_arid     = m1_arid;
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
        end else begin
          s_arvalid  = m0_arvalid;
          s_arid     = m0_arid;
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
        end
        if (ar_vld_sel && s_arready) state_nxt = RDATA;
      end

      RDATA: begin
        s_rready = r_rdy_sel;
        if (owner) begin
          m1_rvalid = s_rvalid;
          m1_rid    = s_rid;
          m1_rresp  = s_rresp;
          m1_rdata  = s_rdata;
          m1_rlast  = s_rlast;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rid    = s_rid;
          m0_rresp  = s_rresp;
          m0_rdata  = s_rdata;
          m0_rlast  = s_rlast;
        end
        if (s_rvalid && r_rdy_sel && s_rlast) state_nxt = IDLE;
      end

      WADDR: begin
        s_awvalid  = m1_awvalid;
        s_awid     = m1_awid;
        s_awaddr   = m1_awaddr;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready;
        if (m1_awvalid && s_awready) state_nxt = WDATA;
      end

      WDATA: begin
        s_wvalid  = m1_wvalid;
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
        s_wlast   = m1_wlast;
        m1_wready = s_wready;
        if (m1_wvalid && s_wready && m1_wlast) state_nxt = WRESP;
      end

      WRESP: begin
        m1_bvalid = s_bvalid;
        m1_bid    = s_bid;
        m1_bresp  = s_bresp;
        s_bready  = m1_bready;
        if (s_bvalid && m1_bready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: bench acts as both masters and the slave, table rounds plus random rounds
// checked against a transaction-level round-robin model.
module tb_axi_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // request slots: 0 = M0 read, 1 = M1 read, 2 = M1 write
  logic            req_v     [3];
  logic [IDW-1:0]  req_id    [3];
  logic [AW-1:0]   req_addr  [3];
  logic [7:0]      req_len   [3];
  logic [2:0]      req_size  [3];
  logic [1:0]      req_burst [3];
  logic [DW-1:0]   req_base  [3];

  logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [IDW-1:0] m0_arid, m0_rid;
  logic [AW-1:0] m0_araddr;
  logic [7:0] m0_arlen;
  logic [2:0] m0_arsize;
  logic [1:0] m0_arburst, m0_rresp;
  logic [DW-1:0] m0_rdata;

  logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [IDW-1:0] m1_arid, m1_rid;
  logic [AW-1:0] m1_araddr;
  logic [7:0] m1_arlen;
  logic [2:0] m1_arsize;
  logic [1:0] m1_arburst, m1_rresp;
  logic [DW-1:0] m1_rdata;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [IDW-1:0] m1_awid, m1_bid;
  logic [AW-1:0] m1_awaddr;
  logic [7:0] m1_awlen;
  logic [2:0] m1_awsize;
  logic [1:0] m1_awburst, m1_bresp;
  logic [DW-1:0] m1_wdata;
  logic [DW/8-1:0] m1_wstrb;

  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [IDW-1:0] s_arid, s_rid;
  logic [AW-1:0] s_araddr;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst, s_rresp;
  logic [DW-1:0] s_rdata;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [IDW-1:0] s_awid, s_bid;
  logic [AW-1:0] s_awaddr;
  logic [7:0] s_awlen;
  logic [2:0] s_awsize;
  logic [1:0] s_awburst, s_bresp;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_wstrb;

  assign m0_arvalid = req_v[0];
  assign m0_arid    = req_id[0];
  assign m0_araddr  = req_addr[0];
  assign m0_arlen   = req_len[0];
  assign m0_arsize  = req_size[0];
  assign m0_arburst = req_burst[0];
  assign m1_arvalid = req_v[1];
  assign m1_arid    = req_id[1];
  assign m1_araddr  = req_addr[1];
  assign m1_arlen   = req_len[1];
  assign m1_arsize  = req_size[1];
  assign m1_arburst = req_burst[1];
  assign m1_awvalid = req_v[2];
  assign m1_awid    = req_id[2];
  assign m1_awaddr  = req_addr[2];
  assign m1_awlen   = req_len[2];
  assign m1_awsize  = req_size[2];
  assign m1_awburst = req_burst[2];

  axi_master_arbiter #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rid(m0_rid), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rid(m1_rid), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
    .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bready(s_bready)
  );

  logic [11:0] vr;
  logic        pay;
  assign vr  = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  assign pay = |{m0_rid, m0_rresp, m0_rdata, m0_rlast, m1_rid, m1_rresp, m1_rdata, m1_rlast,
                 m1_bid, m1_bresp, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
                 s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_wdata, s_wstrb, s_wlast};

  int total  = 0;
  int passed = 0;
  bit lg     = 1'b1;   // model of who was granted last
  bit directed = 1'b0;
  int force_len = -1;
  bit ok_flag;

  typedef struct {
    bit r0;
    bit r1r;
    bit r1w;
    int exp_k;
  } vec_t;
  vec_t tab [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic ar_rdy(input int k);
    return (k == 0) ? m0_arready : m1_arready;
  endfunction
  function automatic logic r_vld(input int k);
    return (k == 0) ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic [DW-1:0] r_dat(input int k);
    return (k == 0) ? m0_rdata : m1_rdata;
  endfunction
  function automatic logic [IDW+2:0] r_idrl(input int k);
    return (k == 0) ? {m0_rid, m0_rresp, m0_rlast} : {m1_rid, m1_rresp, m1_rlast};
  endfunction

  task automatic set_rready(input int k, input logic v);
    if (k == 0) m0_rready = v;
    else m1_rready = v;
  endtask

  task automatic chk_iso(input int k);
    if (k == 0) chk("iso_m1", 64'({m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}), 64'd0);
    else chk("iso_m0", 64'({m0_arready, m0_rvalid}), 64'd0);
    if (k == 2) chk("iso_rd", 64'({m1_arready, m1_rvalid, s_arvalid, s_rready}), 64'd0);
    else begin
      chk("iso_wr", 64'({s_awvalid, s_wvalid, s_bready}), 64'd0);
      if (k == 1) chk("iso_m1w", 64'({m1_awready, m1_wready, m1_bvalid}), 64'd0);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      req_v[k] = 1'b0; req_id[k] = '0; req_addr[k] = '0; req_len[k] = '0;
      req_size[k] = '0; req_burst[k] = '0; req_base[k] = '0;
    end
    m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
    m1_wvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rresp = '0; s_rdata = '0; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  // Reset with junk on the slave inputs: nothing may leak to either master.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = '1; s_rlast = 1'b1; s_rid = '1;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bid = '1; s_bresp = 2'b11;
    #1;
    chk("rst_vr", 64'(vr), 64'd0);
    chk("rst_pay", 64'(pay), 64'd0);
    repeat (2) @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("post_rst_vr", 64'(vr), 64'd0);
    lg = 1'b1;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (!(s_arvalid || s_awvalid) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("grant_latency", 64'(cyc), 64'd1);
  endtask

  task automatic drop_reqs(input int k, input bit drop_all);
    req_v[k] = 1'b0;
    if (drop_all) for (int j = 0; j < 3; j++) req_v[j] = 1'b0;
  endtask

  task automatic serve_read(input int k, input bit stall, input bit drop_all,
                            input int abort_beat, output bit ok);
    int cyc;
    logic [DW-1:0] d;
    logic [1:0] resp;
    bit last;
    ok = 1'b1;
    wait_grant(cyc);
    chk("grant_chan_rd", 64'({s_arvalid, s_awvalid}), 64'd2);
    if (!(s_arvalid && !s_awvalid)) begin ok = 1'b0; return; end
    chk("s_araddr", 64'(s_araddr), 64'(req_addr[k]));
    chk("s_arid_len", 64'({s_arid, s_arlen, s_arsize, s_arburst}),
        64'({req_id[k], req_len[k], req_size[k], req_burst[k]}));
    chk_iso(k);
    if (stall) repeat ($urandom_range(0, 2)) begin
      chk("ar_hold", 64'({s_arvalid, ar_rdy(k)}), 64'd2);
      @(negedge clk); #1;
    end
    s_arready = 1'b1; #1;
    chk("arready_fwd", 64'(ar_rdy(k)), 64'd1);
    chk_iso(k);
    @(negedge clk);
    s_arready = 1'b0;
    drop_reqs(k, drop_all);
    #1;
    for (int b = 0; b <= int'(req_len[k]); b++) begin
      d    = req_base[k] + 64'(b);
      last = (b == int'(req_len[k]));
      resp = 2'($urandom);
      if (stall) repeat ($urandom_range(0, 2)) begin
        s_rvalid = 1'b0; #1;
        chk("r_gap", 64'(r_vld(k)), 64'd0);
        @(negedge clk);
      end
      s_rvalid = 1'b1; s_rdata = d; s_rid = req_id[k]; s_rresp = resp; s_rlast = last;
      if (stall && $urandom_range(0, 1) == 1) begin
        set_rready(k, 1'b0); #1;
        chk("rready_bp", 64'({s_rready, r_vld(k)}), 64'd1);
        @(negedge clk);
        set_rready(k, 1'b1);
      end
      #1;
      chk("rdata", r_dat(k), d);
      chk("rid_resp_last", 64'(r_idrl(k)), 64'({req_id[k], resp, last}));
      chk("rvalid_rready", 64'({r_vld(k), s_rready}), 64'd3);
      chk_iso(k);
      if (b == abort_beat) begin
        rst = 1'b0; #1;
        chk("abort_vr", 64'(vr), 64'd0);
        chk("abort_pay", 64'(pay), 64'd0);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; #1;
    chk("bubble_rd", 64'({s_arvalid, s_awvalid, vr[11:5]}), 64'd0);
  endtask

  task automatic serve_write(input bit stall, input bit drop_all, output bit ok);
    int cyc;
    int tries;
    bit acc;
    bit last;
    logic [DW-1:0] d;
    logic [7:0] st;
    logic [1:0] resp;
    ok = 1'b1;
    wait_grant(cyc);
    chk("grant_chan_wr", 64'({s_arvalid, s_awvalid}), 64'd1);
    if (!(s_awvalid && !s_arvalid)) begin ok = 1'b0; return; end
    chk("s_awaddr", 64'(s_awaddr), 64'(req_addr[2]));
    chk("s_awid_len", 64'({s_awid, s_awlen, s_awsize, s_awburst}),
        64'({req_id[2], req_len[2], req_size[2], req_burst[2]}));
    chk_iso(2);
    if (stall) repeat ($urandom_range(0, 2)) begin
      chk("aw_hold", 64'({s_awvalid, m1_awready}), 64'd2);
      @(negedge clk); #1;
    end
    s_awready = 1'b1; #1;
    chk("awready_fwd", 64'(m1_awready), 64'd1);
    chk("ar_held_off", 64'({m0_arready, m1_arready, s_arvalid}), 64'd0);
    @(negedge clk);
    s_awready = 1'b0;
    drop_reqs(2, drop_all);
    for (int b = 0; b <= int'(req_len[2]); b++) begin
      d    = req_base[2] + 64'(b);
      st   = directed ? 8'hFF : 8'($urandom);
      last = (b == int'(req_len[2]));
      m1_wvalid = 1'b1; m1_wdata = d; m1_wstrb = st; m1_wlast = last;
      tries = 0;
      do begin
        s_wready = (stall && tries < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("s_wdata", s_wdata, d);
        chk("s_wstrb_last", 64'({s_wvalid, s_wstrb, s_wlast}), 64'({1'b1, st, last}));
        chk("wready_fwd", 64'(m1_wready), 64'(s_wready));
        chk_iso(2);
        acc = s_wready;
        tries++;
        @(negedge clk);
      end while (!acc);
    end
    m1_wvalid = 1'b0; m1_wlast = 1'b0; m1_wdata = '0; s_wready = 1'b0;
    if (stall) repeat ($urandom_range(0, 2)) begin
      s_bvalid = 1'b0; #1;
      chk("b_gap", 64'(m1_bvalid), 64'd0);
      @(negedge clk);
    end
    resp = directed ? 2'b00 : 2'($urandom);
    s_bvalid = 1'b1; s_bid = req_id[2]; s_bresp = resp;
    if (stall && $urandom_range(0, 1) == 1) begin
      m1_bready = 1'b0; #1;
      chk("bready_bp", 64'({s_bready, m1_bvalid}), 64'd1);
      @(negedge clk);
      m1_bready = 1'b1;
    end
    #1;
    chk("bvalid_bready", 64'({m1_bvalid, s_bready}), 64'd3);
    chk("bid_bresp", 64'({m1_bid, m1_bresp}), 64'({req_id[2], resp}));
    chk_iso(2);
    @(negedge clk);
    s_bvalid = 1'b0; s_bid = '0; s_bresp = '0; #1;
    chk("bubble_wr", 64'({s_arvalid, s_awvalid, vr[11:5]}), 64'd0);
  endtask

  // exp_k >= 0: table round, only that request is served and the rest withdraw.
  task automatic run_round(input bit r0, input bit r1r, input bit r1w, input int exp_k, input bit stall);
    bit ok;
    int k;
    bit p0, p1, win;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      req_id[j]    = 4'($urandom);
      req_addr[j]  = {4'(j), 28'($urandom)};
      req_len[j]   = (force_len >= 0) ? 8'(force_len) : 8'($urandom_range(0, 3));
      req_size[j]  = 3'($urandom_range(0, 3));
      req_burst[j] = 2'($urandom_range(0, 2));
      req_base[j]  = {$urandom, $urandom};
    end
    if (directed) begin
      req_addr[0] = 32'h0200_bff8; req_len[0] = 8'd0; req_base[0] = 64'h1234;
      req_addr[2] = 32'h0200_4000; req_len[2] = 8'd0; req_base[2] = 64'h10;
      req_size[0] = 3'd3; req_size[2] = 3'd3; req_burst[0] = 2'd1; req_burst[2] = 2'd1;
    end
    req_v[0] = r0; req_v[1] = r1r; req_v[2] = r1w;
    #1;
    while (req_v[0] || req_v[1] || req_v[2]) begin
      if (exp_k >= 0) k = exp_k;
      else begin
        // Round-robin between masters; M1's own write goes before its read.
        p0  = req_v[0];
        p1  = req_v[1] || req_v[2];
        win = (p0 && p1) ? !lg : !p0;
        k   = !win ? 0 : (req_v[2] ? 2 : 1);
      end
      lg = (k != 0);
      if (k == 2) serve_write(stall, exp_k >= 0, ok);
      else serve_read(k, stall, exp_k >= 0, -1, ok);
      if (!ok) begin
        do_reset();
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rv;
    tab[0]  = '{1'b1, 1'b1, 1'b0, 0};   // first tie goes to M0
    tab[1]  = '{1'b1, 1'b1, 1'b0, 1};
    tab[2]  = '{1'b1, 1'b1, 1'b0, 0};
    tab[3]  = '{1'b1, 1'b1, 1'b0, 1};
    tab[4]  = '{1'b0, 1'b1, 1'b1, 2};
    tab[5]  = '{1'b1, 1'b0, 1'b1, 0};
    tab[6]  = '{1'b0, 1'b1, 1'b0, 1};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 2};
    tab[8]  = '{1'b1, 1'b1, 1'b1, 0};
    tab[9]  = '{1'b1, 1'b0, 1'b1, 2};
    tab[10] = '{1'b1, 1'b0, 1'b0, 0};
    tab[11] = '{1'b0, 1'b1, 1'b1, 2};

    clear_inputs();
    do_reset();

    for (int i = 0; i < 12; i++)
      run_round(tab[i].r0, tab[i].r1r, tab[i].r1w, tab[i].exp_k, 1'b0);

    directed = 1'b1;
    run_round(1'b1, 1'b0, 1'b0, -1, 1'b0);   // single M0 read, rdata 0x1234
    run_round(1'b0, 1'b0, 1'b1, -1, 1'b0);   // single M1 write, OKAY
    directed = 1'b0;
    run_round(1'b0, 1'b1, 1'b1, -1, 1'b0);   // M1 write then M1 read

    force_len = 3;
    run_round(1'b1, 1'b0, 1'b0, -1, 1'b1);   // 4-beat burst with slave stalls
    force_len = -1;

    // Reset in the middle of a 4-beat burst.
    @(negedge clk);
    req_id[0] = 4'h5; req_addr[0] = 32'h0200_0000; req_len[0] = 8'd3;
    req_size[0] = 3'd3; req_burst[0] = 2'd1; req_base[0] = 64'hA000;
    req_v[0] = 1'b1;
    #1;
    serve_read(0, 1'b0, 1'b0, 2, ok_flag);
    do_reset();
    run_round(1'b1, 1'b1, 1'b0, 0, 1'b0);    // last_grant back to its reset value

    repeat (40) begin
      rv = 3'($urandom_range(1, 7));
      run_round(rv[0], rv[1], rv[2], -1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
